// File: rtl/ece571f23_g5_aes_addroundkey_stream.sv
// ece571f23_g5_aes_addroundkey_stream
//   Streams a 128-bit AES state through AddRoundKey, LANE_W bits per beat.
//   A round key (and bypass flag) is latched once per state. Each accepted
//   text beat is XORed with the matching key lane and registered onto the
//   output. When bypass is latched, the text passes through unchanged.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   key[127:0]            round key, MSB-first (FIPS-197 byte order)
//   key_valid/key_ready   key + bypass handshake (accepted only in IDLE)
//   bypass                1 = pass text through unmodified
//   in_data/valid/ready   text lane input; beat 0 is the MS lane of the state
//   out_data/valid/ready  result lane output, one register stage
//   out_last              marks the final beat of a state
//   busy                  high whenever not in IDLE
module ece571f23_g5_aes_addroundkey_stream #(
    parameter int unsigned LANE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      key,
    input  logic              key_valid,
    output logic              key_ready,
    input  logic              bypass,
    input  logic [LANE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned BEATS = 128 / LANE_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic               bypass_q, bypass_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;

    logic [127:0]       key_shift;
    logic [LANE_W-1:0]  key_lane;
    int unsigned        shamt;
    logic               out_pop;

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        bypass_d    = bypass_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        key_ready   = 1'b0;
        in_ready    = 1'b0;

        // Shift the current lane of the latched key to the top so beat n
        // picks key[127-n*LANE_W -: LANE_W].
        shamt     = 32'(cnt_q) * LANE_W;
        key_shift = key_q << shamt;
        key_lane  = key_shift[127 -: LANE_W];

        out_pop = out_valid_q && out_ready;
        if (out_pop) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    key_d    = key;
                    bypass_d = bypass;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // A new beat may enter whenever the output slot is empty or
                // being popped this cycle, so push and pop can coincide.
                in_ready = !out_valid_q || out_ready;
                if (in_valid && in_ready) begin
                    out_data_d  = in_data ^ (bypass_q ? '0 : key_lane);
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == LAST_BEAT);
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_pop && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            bypass_q    <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            bypass_q    <= bypass_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ece571f23_g5_aes_addroundkey_stream.sv
// Bench for ece571f23_g5_aes_addroundkey_stream: FIPS-197 round-0 vectors
// at LANE_W = 32, 8 and 128.
module tb_ece571f23_g5_aes_addroundkey_stream;

    localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] EXP = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    logic         clk, rst, out_ready, bypass;
    logic [127:0] key;

    logic         kv32, kr32, iv32, ir32, ov32, ol32, busy32;
    logic [31:0]  id32, od32;
    logic         kv8, kr8, iv8, ir8, ov8, ol8, busy8;
    logic [7:0]   id8, od8;
    logic         kv128, kr128, iv128, ir128, ov128, ol128, busy128;
    logic [127:0] id128, od128;

    ece571f23_g5_aes_addroundkey_stream #(.LANE_W(32)) dut32 (
        .clk(clk), .rst(rst), .key(key), .key_valid(kv32), .key_ready(kr32),
        .bypass(bypass), .in_data(id32), .in_valid(iv32), .in_ready(ir32),
        .out_data(od32), .out_valid(ov32), .out_ready(out_ready),
        .out_last(ol32), .busy(busy32));

    ece571f23_g5_aes_addroundkey_stream #(.LANE_W(8)) dut8 (
        .clk(clk), .rst(rst), .key(key), .key_valid(kv8), .key_ready(kr8),
        .bypass(bypass), .in_data(id8), .in_valid(iv8), .in_ready(ir8),
        .out_data(od8), .out_valid(ov8), .out_ready(out_ready),
        .out_last(ol8), .busy(busy8));

    ece571f23_g5_aes_addroundkey_stream #(.LANE_W(128)) dut128 (
        .clk(clk), .rst(rst), .key(key), .key_valid(kv128), .key_ready(kr128),
        .bypass(bypass), .in_data(id128), .in_valid(iv128), .in_ready(ir128),
        .out_data(od128), .out_valid(ov128), .out_ready(out_ready),
        .out_last(ol128), .busy(busy128));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        last;
    } vec_t;
    vec_t tbl[4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output handshakes of the 32-bit instance, recorded as {last, data};
    // also checks that a stalled output holds still.
    logic [32:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 128'(ov32), 128'(1'b1));
                chk("hold_data", 128'(od32), 128'(prev_data));
                chk("hold_last", 128'(ol32), 128'(prev_last));
            end
            if (ov32 === 1'b1 && out_ready === 1'b1) got_q.push_back({ol32, od32});
            prev_stall = (ov32 === 1'b1) && (out_ready === 1'b0);
            prev_data  = od32;
            prev_last  = ol32;
        end
    end

    task automatic load_key32(input logic [127:0] k, input logic b);
        key    = k;
        bypass = b;
        kv32   = 1'b1;
        tick();
        kv32 = 1'b0;
        chk("run_key_ready", 128'(kr32), 128'(1'b0));
        chk("run_busy", 128'(busy32), 128'(1'b1));
    endtask

    task automatic send_beat32(input int i, input logic b);
        id32 = tbl[i].din;
        iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        chk($sformatf("beat%0d_valid", i), 128'(ov32), 128'(1'b1));
        chk($sformatf("beat%0d_data", i), 128'(od32), 128'(b ? tbl[i].din : tbl[i].dout));
        chk($sformatf("beat%0d_last", i), 128'(ol32), 128'(tbl[i].last));
    endtask

    task automatic chk_idle32(input string tag);
        chk({tag, "_out_valid"}, 128'(ov32), 128'(1'b0));
        chk({tag, "_key_ready"}, 128'(kr32), 128'(1'b1));
        chk({tag, "_busy"}, 128'(busy32), 128'(1'b0));
    endtask

    task automatic chk_got(input string tag, input logic b);
        chk({tag, "_count"}, 128'(got_q.size()), 128'(4));
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            chk($sformatf("%s_got%0d", tag, i), 128'(got_q[i]),
                128'({tbl[i].last, (b ? tbl[i].din : tbl[i].dout)}));
        end
    endtask

    initial begin
        bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          sent;
        logic        acc;
        logic [31:0] w;

        tbl[0] = '{32'h3243f6a8, 32'h193de3be, 1'b0};
        tbl[1] = '{32'h885a308d, 32'ha0f4e22b, 1'b0};
        tbl[2] = '{32'h313198a2, 32'h9ac68d2a, 1'b0};
        tbl[3] = '{32'he0370734, 32'he9f84808, 1'b1};

        rst = 1'b1; out_ready = 1'b1; key = '0; bypass = 1'b0;
        kv32 = 0; iv32 = 0; id32 = '0;
        kv8 = 0; iv8 = 0; id8 = '0;
        kv128 = 0; iv128 = 0; id128 = '0;
        #12;

        // Reset state
        chk("rst_out_valid", 128'(ov32), 128'(1'b0));
        chk("rst_out_last", 128'(ol32), 128'(1'b0));
        chk("rst_out_data", 128'(od32), 128'(32'h0));
        chk("rst_in_ready", 128'(ir32), 128'(1'b0));
        chk_idle32("rst");
        tick();
        rst = 1'b0;
        tick();

        // Back-to-back block, latency 1
        got_q.delete();
        load_key32(K, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_beat32(i, 1'b0);
            chk($sformatf("beat%0d_in_ready", i), 128'(ir32), 128'(i < 3));
        end
        chk("drain_busy", 128'(busy32), 128'(1'b1));
        tick();
        chk_idle32("t1_end");
        chk_got("t1", 1'b0);

        // Output stalls with out_ready pattern 1-0-0-1
        got_q.delete();
        load_key32(K, 1'b0);
        sent = 0;
        for (int cyc = 0; cyc < 60 && got_q.size() < 4; cyc++) begin
            out_ready = pat[cyc % 4];
            iv32 = (sent < 4);
            if (sent < 4) id32 = tbl[sent].din;
            #1;
            acc = iv32 && ir32;
            tick();
            if (acc) sent++;
        end
        iv32 = 1'b0;
        out_ready = 1'b1;
        chk("t2_sent", 128'(sent), 128'(4));
        chk_got("t2", 1'b0);
        tick();
        chk_idle32("t2_end");

        // Bypass
        got_q.delete();
        load_key32(K, 1'b1);
        for (int i = 0; i < 4; i++) send_beat32(i, 1'b1);
        tick();
        chk_idle32("t3_end");
        chk_got("t3", 1'b1);

        // Reset mid-block, then a full fresh block
        load_key32(K, 1'b0);
        send_beat32(0, 1'b0);
        send_beat32(1, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_data", 128'(od32), 128'(32'h0));
        chk("mid_rst_out_last", 128'(ol32), 128'(1'b0));
        chk("mid_rst_in_ready", 128'(ir32), 128'(1'b0));
        chk_idle32("mid_rst");
        tick();
        rst = 1'b0;
        got_q.delete();
        id32 = tbl[2].din;
        iv32 = 1'b1;
        tick();
        tick();
        chk("idle_ignores_in_valid", 128'(ov32), 128'(1'b0));
        chk("idle_in_ready", 128'(ir32), 128'(1'b0));
        iv32 = 1'b0;
        load_key32(K, 1'b0);
        for (int i = 0; i < 4; i++) send_beat32(i, 1'b0);
        tick();
        chk_got("t4", 1'b0);

        // Key offered during RUN is ignored; key/bypass inputs changed afterwards
        load_key32(K, 1'b0);
        send_beat32(0, 1'b0);
        key = ~K;
        bypass = 1'b1;
        kv32 = 1'b1;
        #1;
        chk("run_key_pulse_ready", 128'(kr32), 128'(1'b0));
        tick();
        kv32 = 1'b0;
        chk("run_key_pulse_busy", 128'(busy32), 128'(1'b1));
        for (int i = 1; i < 4; i++) send_beat32(i, 1'b0);
        tick();
        chk_idle32("t5_end");
        key = K;
        bypass = 1'b0;

        // LANE_W = 8
        kv8 = 1'b1;
        tick();
        kv8 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = tbl[i / 4].din;
            id8 = w[31 - 8 * (i % 4) -: 8];
            iv8 = 1'b1;
            tick();
            w = tbl[i / 4].dout;
            chk($sformatf("b8_%0d_valid", i), 128'(ov8), 128'(1'b1));
            chk($sformatf("b8_%0d_data", i), 128'(od8), 128'(w[31 - 8 * (i % 4) -: 8]));
            chk($sformatf("b8_%0d_last", i), 128'(ol8), 128'(i == 15));
        end
        iv8 = 1'b0;
        tick();
        chk("b8_end_valid", 128'(ov8), 128'(1'b0));
        chk("b8_end_key_ready", 128'(kr8), 128'(1'b1));

        // LANE_W = 128
        kv128 = 1'b1;
        tick();
        kv128 = 1'b0;
        id128 = T;
        iv128 = 1'b1;
        tick();
        iv128 = 1'b0;
        chk("b128_valid", 128'(ov128), 128'(1'b1));
        chk("b128_data", od128, EXP);
        chk("b128_last", 128'(ol128), 128'(1'b1));
        chk("b128_in_ready_drain", 128'(ir128), 128'(1'b0));
        chk("b128_busy_drain", 128'(busy128), 128'(1'b1));
        tick();
        chk("b128_end_busy", 128'(busy128), 128'(1'b0));
        chk("b128_end_valid", 128'(ov128), 128'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
